uart_tx: RTL and testbench

//   UART transmitter: serialises parallel bytes onto the async line that the receive side samples.

---
 rtl/uart_tx.sv | 198 +++++++++++++++++++
 tb/tb_uart_tx.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// uart_tx: UART transmitter clocked at the oversampled baud rate.
// Frame on the line: start (0), data LSB first, optional parity, STOP_BITS stop (1).
// One bit period lasts OVERSAMPLE clk cycles. A holding register in front of
// the shift register lets the next frame start right after the last stop bit.
// The line output is registered from the current state, so tx goes low on the
// edge after the FSM enters START.
module uart_tx #(
   parameter int DATA_BITS  = 8,
   parameter int OVERSAMPLE = 16,
   parameter bit PARITY_EN  = 1'b0,
   parameter bit PARITY_ODD = 1'b0,
   parameter int STOP_BITS  = 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [DATA_BITS-1:0] tx_data,
   input  logic                 tx_valid,
   output logic                 tx_ready,
   output logic                 tx,
   output logic                 busy
);

   localparam int BAUD_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
   localparam int BIT_W  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(OVERSAMPLE - 1);
   localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_BITS - 1);
   localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } state_t;

   state_t                 state_q,     state_d;
   logic [BAUD_W-1:0]      baud_cnt_q,  baud_cnt_d;
   logic [BIT_W-1:0]       bit_cnt_q,   bit_cnt_d;
   logic [DATA_BITS-1:0]   shift_q,     shift_d;
   logic                   parity_q,    parity_d;
   logic [DATA_BITS-1:0]   hold_q,      hold_d;
   logic                   hold_full_q, hold_full_d;
   logic                   tx_q,        tx_d;
   logic                   tx_ready_q,  tx_ready_d;
   logic                   busy_q,      busy_d;

   logic baud_last;
   logic transfer;
   logic accept;

   // Next-state logic: frame sequencing, holding-register handshake, line value.
   always_comb begin
      // NOTE: every _d takes its _q value first, so no branch can leave a latch behind.
      state_d     = state_q;
      baud_cnt_d  = baud_cnt_q;
      bit_cnt_d   = bit_cnt_q;
      shift_d     = shift_q;
      parity_d    = parity_q;
      hold_d      = hold_q;
      hold_full_d = hold_full_q;
      transfer    = 1'b0;

      baud_last = (baud_cnt_q == BAUD_LAST);
      accept    = tx_valid && tx_ready_q;

      case (state_q)
         IDLE: begin
            baud_cnt_d = '0;
            bit_cnt_d  = '0;
            if (hold_full_q) begin
               transfer = 1'b1;
            end
         end

         START: begin
            if (baud_last) begin
               baud_cnt_d = '0;
               bit_cnt_d  = '0;
               state_d    = DATA;
            end else begin
               baud_cnt_d = baud_cnt_q + 1'b1;
            end
         end

         DATA: begin
            if (baud_last) begin
               baud_cnt_d = '0;
               shift_d    = shift_q >> 1;
               if (bit_cnt_q == DATA_LAST) begin
                  bit_cnt_d = '0;
                  state_d   = PARITY_EN ? PARITY : STOP;
               end else begin
                  bit_cnt_d = bit_cnt_q + 1'b1;
               end
            end else begin
               baud_cnt_d = baud_cnt_q + 1'b1;
            end
         end

         PARITY: begin
            if (baud_last) begin
               baud_cnt_d = '0;
               bit_cnt_d  = '0;
               state_d    = STOP;
            end else begin
               baud_cnt_d = baud_cnt_q + 1'b1;
            end
         end

         STOP: begin
            if (baud_last) begin
               baud_cnt_d = '0;
               if (bit_cnt_q == STOP_LAST) begin
                  bit_cnt_d = '0;
                  // A waiting byte starts its frame with no idle cycle in between.
                  if (hold_full_q) begin
                     transfer = 1'b1;
                  end else begin
                     state_d = IDLE;
                  end
               end else begin
                  bit_cnt_d = bit_cnt_q + 1'b1;
               end
            end else begin
               baud_cnt_d = baud_cnt_q + 1'b1;
            end
         end

         default: begin
            state_d    = IDLE;
            baud_cnt_d = '0;
            bit_cnt_d  = '0;
         end
      endcase

      // Move the buffered byte into the shifter; parity is taken from the byte as loaded.
      if (transfer) begin
         shift_d     = hold_q;
         parity_d    = (^hold_q) ^ PARITY_ODD;
         hold_full_d = 1'b0;
         baud_cnt_d  = '0;
         bit_cnt_d   = '0;
         state_d     = START;
      end

      // A new byte wins over the transfer, so the holding register stays full.
      if (accept) begin
         hold_d      = tx_data;
         hold_full_d = 1'b1;
      end

      // The line follows the current state, one clk behind the state register.
      case (state_q)
         START:   tx_d = 1'b0;
         DATA:    tx_d = shift_q[0];
         PARITY:  tx_d = parity_q;
         default: tx_d = 1'b1;
      endcase

      tx_ready_d = !hold_full_d;
      busy_d     = (state_d != IDLE) || hold_full_d;
   end

   // State, counters, buffers and registered outputs; reset abandons any frame in flight.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         baud_cnt_q  <= '0;
         bit_cnt_q   <= '0;
         shift_q     <= '0;
         parity_q    <= 1'b0;
         hold_q      <= '0;
         hold_full_q <= 1'b0;
         tx_q        <= 1'b1;
         tx_ready_q  <= 1'b1;
         busy_q      <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments, so every flop samples its pre-edge inputs.
         state_q     <= state_d;
         baud_cnt_q  <= baud_cnt_d;
         bit_cnt_q   <= bit_cnt_d;
         shift_q     <= shift_d;
         parity_q    <= parity_d;
         hold_q      <= hold_d;
         hold_full_q <= hold_full_d;
         tx_q        <= tx_d;
         tx_ready_q  <= tx_ready_d;
         busy_q      <= busy_d;
      end
   end

   assign tx       = tx_q;
   assign tx_ready = tx_ready_q;
   assign busy     = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed bench for uart_tx. It uses four configurations: the default
// 8N1, 8E1, 8O1, and 7N2. Each expected frame is a hand-computed vector.
// Bit i of the vector is the i-th bit period on the line.
module tb_uart_tx;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   logic [7:0] d0, d1, d2;
   logic [6:0] d3;
   logic       v0, v1, v2, v3;
   logic       r0, r1, r2, r3;
   logic       t0, t1, t2, t3;
   logic       b0, b1, b2, b3;

   int checks = 0;
   int errors = 0;
   int sel    = 0;

   uart_tx u0 (.clk(clk), .reset(reset), .tx_data(d0), .tx_valid(v0),
               .tx_ready(r0), .tx(t0), .busy(b0));

   uart_tx #(.PARITY_EN(1'b1), .PARITY_ODD(1'b0)) u1 (
      .clk(clk), .reset(reset), .tx_data(d1), .tx_valid(v1),
      .tx_ready(r1), .tx(t1), .busy(b1));

   uart_tx #(.PARITY_EN(1'b1), .PARITY_ODD(1'b1)) u2 (
      .clk(clk), .reset(reset), .tx_data(d2), .tx_valid(v2),
      .tx_ready(r2), .tx(t2), .busy(b2));

   uart_tx #(.DATA_BITS(7), .STOP_BITS(2)) u3 (
      .clk(clk), .reset(reset), .tx_data(d3), .tx_valid(v3),
      .tx_ready(r3), .tx(t3), .busy(b3));

   function automatic logic tx_obs();
      case (sel)
         0:       return t0;
         1:       return t1;
         2:       return t2;
         default: return t3;
      endcase
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // The call starts at the first cycle of the start bit. It checks the first and
   // last cycle of each bit period. It returns on the first cycle after the frame.
   task automatic check_frame(input string tag, input logic [11:0] frame, input int len);
      for (int i = 0; i < len; i++) begin
         chk($sformatf("%s bit%0d first", tag, i), {31'd0, tx_obs()}, {31'd0, frame[i]});
         repeat (15) tick();
         chk($sformatf("%s bit%0d last", tag, i), {31'd0, tx_obs()}, {31'd0, frame[i]});
         tick();
      end
   endtask

   initial begin
      reset = 1'b1;
      d0 = '0; d1 = '0; d2 = '0; d3 = '0;
      v0 = 1'b0; v1 = 1'b0; v2 = 1'b0; v3 = 1'b0;

      // Reset state.
      #3;
      chk("reset tx",    {31'd0, t0}, 32'd1);
      chk("reset ready", {31'd0, r0}, 32'd1);
      chk("reset busy",  {31'd0, b0}, 32'd0);
      chk("reset tx u3", {31'd0, t3}, 32'd1);
      #9 reset = 1'b0;
      tick();

      // Test 1: 0x55 with default framing and the exact latency.
      sel = 0;
      d0 = 8'h55; v0 = 1'b1;
      tick();
      v0 = 1'b0;
      chk("t1 ready after accept", {31'd0, r0}, 32'd0);
      chk("t1 busy after accept",  {31'd0, b0}, 32'd1);
      chk("t1 tx at N",            {31'd0, t0}, 32'd1);
      tick();
      chk("t1 tx at N+1",          {31'd0, t0}, 32'd1);
      tick();
      check_frame("t1 0x55", 12'h2AA, 10);
      chk("t1 busy after", {31'd0, b0}, 32'd0);
      chk("t1 ready after", {31'd0, r0}, 32'd1);
      chk("t1 tx idle",    {31'd0, t0}, 32'd1);

      // Test 2: back-to-back 0xA5 then 0x3C with no idle gap.
      d0 = 8'hA5; v0 = 1'b1;
      tick();
      v0 = 1'b0;
      tick();
      chk("t2 ready after transfer", {31'd0, r0}, 32'd1);
      d0 = 8'h3C; v0 = 1'b1;
      tick();
      v0 = 1'b0;
      chk("t2 ready after 2nd accept", {31'd0, r0}, 32'd0);
      chk("t2 busy", {31'd0, b0}, 32'd1);
      check_frame("t2 0xA5", 12'h34A, 10);
      check_frame("t2 0x3C", 12'h278, 10);
      chk("t2 busy after", {31'd0, b0}, 32'd0);

      // Test 3: even parity for 0x07 and 0x03, then odd parity for 0x07 (176 clk frames).
      sel = 1;
      d1 = 8'h07; v1 = 1'b1;
      tick();
      v1 = 1'b0;
      tick();
      tick();
      check_frame("t3 even 0x07", 12'h60E, 11);
      chk("t3 busy even a", {31'd0, b1}, 32'd0);
      d1 = 8'h03; v1 = 1'b1;
      tick();
      v1 = 1'b0;
      tick();
      tick();
      check_frame("t3 even 0x03", 12'h406, 11);
      chk("t3 busy even b", {31'd0, b1}, 32'd0);
      sel = 2;
      d2 = 8'h07; v2 = 1'b1;
      tick();
      v2 = 1'b0;
      tick();
      tick();
      check_frame("t3 odd 0x07", 12'h40E, 11);
      chk("t3 busy odd", {31'd0, b2}, 32'd0);

      // Test 4: backpressure with tx_valid held high across 0x11, 0x22, 0x33.
      sel = 0;
      d0 = 8'h11; v0 = 1'b1;
      tick();
      d0 = 8'h22;
      chk("t4 ready blocked 0x22", {31'd0, r0}, 32'd0);
      tick();
      tick();
      d0 = 8'h33;
      chk("t4 ready after 0x22 accept", {31'd0, r0}, 32'd0);
      check_frame("t4 0x11", 12'h222, 10);
      v0 = 1'b0;
      chk("t4 ready holding 0x33", {31'd0, r0}, 32'd0);
      chk("t4 busy", {31'd0, b0}, 32'd1);
      check_frame("t4 0x22", 12'h244, 10);
      check_frame("t4 0x33", 12'h266, 10);
      chk("t4 busy after", {31'd0, b0}, 32'd0);

      // Test 5: reset during data bit 3 of 0xF0, then a clean 0x81.
      d0 = 8'hF0; v0 = 1'b1;
      tick();
      v0 = 1'b0;
      tick();
      tick();
      repeat (72) tick();
      chk("t5 tx bit3 before reset", {31'd0, t0}, 32'd0);
      #2 reset = 1'b1;
      #1;
      chk("t5 tx on reset",    {31'd0, t0}, 32'd1);
      chk("t5 ready on reset", {31'd0, r0}, 32'd1);
      chk("t5 busy on reset",  {31'd0, b0}, 32'd0);
      @(posedge clk);
      #2 reset = 1'b0;
      repeat (3) tick();
      chk("t5 tx idle after reset",   {31'd0, t0}, 32'd1);
      chk("t5 busy idle after reset", {31'd0, b0}, 32'd0);
      d0 = 8'h81; v0 = 1'b1;
      tick();
      v0 = 1'b0;
      tick();
      tick();
      check_frame("t5 0x81", 12'h302, 10);
      chk("t5 busy after", {31'd0, b0}, 32'd0);

      // Test 6: 7 data bits and 2 stop bits, 0x7F in a 160 clk frame.
      sel = 3;
      d3 = 7'h7F; v3 = 1'b1;
      tick();
      v3 = 1'b0;
      tick();
      tick();
      check_frame("t6 0x7F", 12'h3FE, 10);
      chk("t6 busy after", {31'd0, b3}, 32'd0);
      chk("t6 tx idle",    {31'd0, t3}, 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
